// File: rtl/hermitian_transpose_stream.sv
// hermitian_transpose_stream: reads a ROWS x COLS complex matrix from BRAM and streams its conjugate transpose
module hermitian_transpose_stream #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 10,
    parameter int ROWS       = 8,
    parameter int COLS       = 4,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_rd_en,
    output logic [ADDR_WIDTH-1:0] bram_rd_addr,
    input  logic [DATA_WIDTH-1:0] bram_rd_real,
    input  logic [DATA_WIDTH-1:0] bram_rd_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_real,
    output logic [DATA_WIDTH-1:0] out_imag,
    output logic                  out_eol,
    output logic                  out_last
);
    localparam int unsigned DEPTH = LATENCY + 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int JW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state;

    logic [IW-1:0] i_cnt;
    logic [JW-1:0] j_cnt;
    logic [ADDR_WIDTH-1:0] col_addr, cur_addr, col_cur, addr_cur;
    logic tag_eol, tag_last;
    logic [LATENCY-1:0] pv, pe, pl;
    logic [DATA_WIDTH-1:0] mem_re [DEPTH];
    logic [DATA_WIDTH-1:0] mem_im [DEPTH];
    logic [DEPTH-1:0] mem_eol, mem_last;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic idle, row_end, col_end, push, pop, credit, issue, last_rd, last_hs;
    logic [DATA_WIDTH-1:0] conj_im;

    always_comb begin
        idle      = state == IDLE;
        row_end   = j_cnt == JW'(ROWS - 1);
        col_end   = i_cnt == IW'(COLS - 1);
        addr_cur  = idle ? base_addr : cur_addr;
        col_cur   = idle ? base_addr : col_addr;
        out_valid = count != '0;
        out_real  = out_valid ? mem_re[rd_ptr] : '0;
        out_imag  = out_valid ? mem_im[rd_ptr] : '0;
        out_eol   = out_valid & mem_eol[rd_ptr];
        out_last  = out_valid & mem_last[rd_ptr];
        push      = pv[LATENCY-1];
        pop       = out_valid & out_ready;
        // a read reserves a FIFO slot up front, so backpressure can never drop returning data
        credit    = 32'(count) + 32'($countones(pv)) + 32'(bram_rd_en) < 32'(DEPTH) + 32'(pop);
        issue     = idle ? start : (state == RUN) & credit;
        last_rd   = issue & row_end & col_end;
        last_hs   = (state == DRAIN) & pop & out_last;
        conj_im   = (bram_rd_imag == MIN_VAL) ? ~MIN_VAL : -bram_rd_imag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            bram_rd_en   <= 1'b0;
            bram_rd_addr <= '0;
            tag_eol      <= 1'b0;
            tag_last     <= 1'b0;
            i_cnt        <= '0;
            j_cnt        <= '0;
            col_addr     <= '0;
            cur_addr     <= '0;
        end else begin
            bram_rd_en <= issue;
            done       <= last_hs;
            if (issue) begin
                bram_rd_addr <= addr_cur;
                tag_eol      <= row_end;
                tag_last     <= row_end & col_end;
                j_cnt        <= row_end ? '0 : j_cnt + JW'(1);
                i_cnt        <= row_end ? (col_end ? '0 : i_cnt + IW'(1)) : i_cnt;
                col_addr     <= row_end ? col_cur + ADDR_WIDTH'(1) : col_cur;
                cur_addr     <= row_end ? col_cur + ADDR_WIDTH'(1) : addr_cur + ADDR_WIDTH'(COLS);
            end
            if (last_rd)
                state <= DRAIN;
            else if (idle && start)
                state <= RUN;
            else if (last_hs)
                state <= DONE;
            else if (state == DONE)
                state <= IDLE;
            if (idle && start)
                busy <= 1'b1;
            else if (last_hs)
                busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv     <= '0;
            pe     <= '0;
            pl     <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            pv[0] <= bram_rd_en;
            pe[0] <= tag_eol;
            pl[0] <= tag_last;
            for (int k = 1; k < LATENCY; k++) begin
                pv[k] <= pv[k-1];
                pe[k] <= pe[k-1];
                pl[k] <= pl[k-1];
            end
            if (push)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_re[wr_ptr]   <= bram_rd_real;
            mem_im[wr_ptr]   <= conj_im;
            mem_eol[wr_ptr]  <= pe[LATENCY-1];
            mem_last[wr_ptr] <= pl[LATENCY-1];
        end
    end
endmodule

// File: tb/tb_hermitian_transpose_stream.sv
// tb_hermitian_transpose_stream: randomized bench comparing the streamed A^H against an index-arithmetic model
module tb_hermitian_transpose_stream;
    localparam int DW = 24, AW = 10, ROWS = 2, COLS = 3, LAT = 2, N = ROWS * COLS;

    logic clk, rst, start, busy, done, bram_rd_en, out_valid, out_ready, out_eol, out_last;
    logic [AW-1:0] base_addr, bram_rd_addr;
    logic [DW-1:0] bram_rd_real, bram_rd_imag, out_real, out_imag;

    int errors = 0, checks = 0, cyc = 0, rmode = 0;
    int mem_re [1024];
    int mem_im [1024];
    logic [DW-1:0] bre [LAT];
    logic [DW-1:0] bim [LAT];
    logic [2*DW+1:0] got_q [$];
    int got_cyc [$], addr_q [$], rd_cyc_q [$], ov_rise_q [$];
    int done_cnt = 0, done_cyc = 0, busy_rises = 0, stall_err = 0;
    bit prev_stall, prev_ov, prev_busy;
    logic [2*DW+1:0] p_out;
    int s_got, s_addr, s_done, s_rise, s_ov;

    hermitian_transpose_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROWS(ROWS), .COLS(COLS), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .busy(busy), .done(done),
        .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_rd_real(bram_rd_real),
        .bram_rd_imag(bram_rd_imag), .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag), .out_eol(out_eol), .out_last(out_last)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM: address sampled on the edge after rd_en, data valid LAT cycles after rd_en; junk otherwise
    always @(posedge clk) begin
        bre[0] <= bram_rd_en ? DW'(mem_re[bram_rd_addr]) : DW'($urandom);
        bim[0] <= bram_rd_en ? DW'(mem_im[bram_rd_addr]) : DW'($urandom);
        for (int k = 1; k < LAT; k++) begin
            bre[k] <= bre[k-1];
            bim[k] <= bim[k-1];
        end
    end
    assign bram_rd_real = bre[LAT-1];
    assign bram_rd_imag = bim[LAT-1];

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1 out_ready = (rmode == 0) ? 1'b1 : ($urandom_range(1) == 1);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            prev_ov = 0;
            prev_busy = 0;
        end else begin
            if (bram_rd_en) begin
                addr_q.push_back(int'(bram_rd_addr));
                rd_cyc_q.push_back(cyc);
            end
            if (out_valid && !prev_ov) ov_rise_q.push_back(cyc);
            if (prev_stall && (!out_valid || {out_real, out_imag, out_eol, out_last} !== p_out)) stall_err++;
            if (out_valid && out_ready) begin
                got_q.push_back({out_real, out_imag, out_eol, out_last});
                got_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy && !prev_busy) busy_rises++;
            prev_stall = out_valid && !out_ready;
            prev_ov = out_valid;
            prev_busy = busy;
            p_out = {out_real, out_imag, out_eol, out_last};
        end
    end

    function automatic int exp_addr(int base, int k);
        return (base + (k % ROWS) * COLS + k / ROWS) % 1024;
    endfunction

    function automatic logic [2*DW+1:0] exp_elem(int base, int k);
        int a = exp_addr(base, k);
        int v = mem_im[a];
        logic [DW-1:0] im = (v == -(1 << (DW - 1))) ? DW'((1 << (DW - 1)) - 1) : DW'(-v);
        return {DW'(mem_re[a]), im, (k % ROWS) == ROWS - 1, k == N - 1};
    endfunction

    task automatic fill_random();
        for (int a = 0; a < 1024; a++) begin
            mem_re[a] = int'($urandom_range(16777215)) - 8388608;
            mem_im[a] = int'($urandom_range(16777215)) - 8388608;
        end
    endtask

    task automatic run_frame(input int base, input bit spam);
        s_got = got_q.size(); s_addr = addr_q.size(); s_done = done_cnt;
        s_rise = busy_rises; s_ov = ov_rise_q.size();
        @(posedge clk);
        #1 base_addr = AW'(base); start = 1;
        @(posedge clk);
        #1 start = 0;
        for (int t = 0; t < 400 && done_cnt == s_done; t++) begin
            @(posedge clk);
            #1 start = spam && busy && ($urandom_range(2) == 0);
            if (spam) base_addr = AW'($urandom);
        end
        start = 0;
        checks++;
        if (done_cnt == s_done) begin
            errors++;
            $display("FAIL frame_timeout: done pulses=0 required=1");
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; base_addr = '0; rmode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, bram_rd_en, out_valid, out_eol, out_last} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000", {busy, done, bram_rd_en, out_valid, out_eol, out_last});
        end
        checks++;
        if (bram_rd_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %0d required 0", bram_rd_addr);
        end
        checks++;
        if ({out_real, out_imag} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {out_real, out_imag});
        end
        rst = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_transpose();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                mem_re[r * COLS + c] = 10 * r + c;
                mem_im[r * COLS + c] = r + c + 1;
            end
        rmode = 0;
        run_frame(0, 0);
        checks++;
        if (got_q.size() - s_got !== N) begin
            errors++;
            $display("FAIL t1_count: got %0d required %0d", got_q.size() - s_got, N);
        end
        for (int k = 0; k < N && s_got + k < got_q.size(); k++) begin
            checks++;
            if (got_q[s_got + k] !== exp_elem(0, k)) begin
                errors++;
                $display("FAIL t1_elem%0d: got %h required %h", k, got_q[s_got + k], exp_elem(0, k));
            end
        end
        checks++;
        if (got_q.size() > s_got && got_q[s_got][2*DW+1:DW+2] !== 24'd0 || got_q.size() > s_got && got_q[s_got][DW+1:2] !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL t1_first: got %h required re=0 im=-1", got_q[s_got]);
        end
        checks++;
        if (ov_rise_q.size() <= s_ov || ov_rise_q[s_ov] - rd_cyc_q[s_addr] !== LAT + 1) begin
            errors++;
            $display("FAIL t1_latency: got %0d required %0d", ov_rise_q.size() > s_ov ? ov_rise_q[s_ov] - rd_cyc_q[s_addr] : -1, LAT + 1);
        end
        checks++;
        if (got_cyc.size() < s_got + N || done_cyc !== got_cyc[s_got + N - 1] + 1) begin
            errors++;
            $display("FAIL t1_done_timing: got cycle %0d required one after last handshake", done_cyc);
        end
        checks++;
        if (busy_rises - s_rise !== 1) begin
            errors++;
            $display("FAIL t1_busy: got %0d busy rises required 1", busy_rises - s_rise);
        end
    endtask

    task automatic test_saturation();
        fill_random();
        mem_im[exp_addr(5, 1)] = -8388608;
        mem_im[exp_addr(5, 4)] = 8388607;
        rmode = 0;
        run_frame(5, 0);
        for (int k = 0; k < N && s_got + k < got_q.size(); k++) begin
            checks++;
            if (got_q[s_got + k] !== exp_elem(5, k)) begin
                errors++;
                $display("FAIL t2_elem%0d: got %h required %h", k, got_q[s_got + k], exp_elem(5, k));
            end
        end
        checks++;
        if (got_q.size() < s_got + N || got_q[s_got + 1][DW+1:2] !== 24'd8388607 || got_q[s_got + 4][DW+1:2] !== 24'h800001) begin
            errors++;
            $display("FAIL t2_saturate: got sizes %0d required im 7fffff and 800001", got_q.size() - s_got);
        end
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                mem_re[r * COLS + c] = 10 * r + c;
                mem_im[r * COLS + c] = r + c + 1;
            end
        rmode = 1;
        for (int rep = 0; rep < 3; rep++) begin
            run_frame(0, 0);
            checks++;
            if (got_q.size() - s_got !== N) begin
                errors++;
                $display("FAIL t3_count: got %0d required %0d", got_q.size() - s_got, N);
            end
            for (int k = 0; k < N && s_got + k < got_q.size(); k++) begin
                checks++;
                if (got_q[s_got + k] !== exp_elem(0, k)) begin
                    errors++;
                    $display("FAIL t3_elem%0d: got %h required %h", k, got_q[s_got + k], exp_elem(0, k));
                end
            end
            checks++;
            if (got_cyc.size() < s_got + N || done_cyc !== got_cyc[s_got + N - 1] + 1) begin
                errors++;
                $display("FAIL t3_done_timing: got cycle %0d required one after last handshake", done_cyc);
            end
        end
        checks++;
        if (stall_err !== 0) begin
            errors++;
            $display("FAIL t3_stable: got %0d changes while stalled required 0", stall_err);
        end
    endtask

    task automatic test_wrap();
        fill_random();
        rmode = 0;
        run_frame(1022, 0);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (s_addr + k >= addr_q.size() || addr_q[s_addr + k] !== exp_addr(1022, k)) begin
                errors++;
                $display("FAIL t4_addr%0d: got %0d required %0d", k, s_addr + k < addr_q.size() ? addr_q[s_addr + k] : -1, exp_addr(1022, k));
            end
        end
        for (int k = 0; k < N && s_got + k < got_q.size(); k++) begin
            checks++;
            if (got_q[s_got + k] !== exp_elem(1022, k)) begin
                errors++;
                $display("FAIL t4_elem%0d: got %h required %h", k, got_q[s_got + k], exp_elem(1022, k));
            end
        end
    endtask

    task automatic test_start_ignored();
        fill_random();
        rmode = 1;
        run_frame(100, 1);
        checks++;
        if (done_cnt - s_done !== 1) begin
            errors++;
            $display("FAIL t5_done_count: got %0d required 1", done_cnt - s_done);
        end
        checks++;
        if (busy_rises - s_rise !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_busy: got %0d rises busy=%b required 1 rise busy=0", busy_rises - s_rise, busy);
        end
        checks++;
        if (addr_q.size() - s_addr !== N || got_q.size() - s_got !== N) begin
            errors++;
            $display("FAIL t5_count: got reads=%0d outs=%0d required %0d", addr_q.size() - s_addr, got_q.size() - s_got, N);
        end
        for (int k = 0; k < N && s_got + k < got_q.size(); k++) begin
            checks++;
            if (got_q[s_got + k] !== exp_elem(100, k)) begin
                errors++;
                $display("FAIL t5_elem%0d: got %h required %h", k, got_q[s_got + k], exp_elem(100, k));
            end
        end
    endtask

    task automatic test_reset_midrun();
        int d0;
        fill_random();
        rmode = 0;
        d0 = done_cnt;
        @(posedge clk);
        #1 base_addr = AW'(200); start = 1;
        @(posedge clk);
        #1 start = 0;
        @(posedge clk);
        #3 rst = 1;
        #1;
        checks++;
        if ({busy, done, bram_rd_en, out_valid, out_eol, out_last} !== 6'b0 || {out_real, out_imag} !== '0) begin
            errors++;
            $display("FAIL t6_async_clear: got flags %b data %h required 0", {busy, done, bram_rd_en, out_valid, out_eol, out_last}, {out_real, out_imag});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL t6_no_done: got %0d done pulses required 0", done_cnt - d0);
        end
        fill_random();
        run_frame(300, 0);
        checks++;
        if (got_q.size() - s_got !== N) begin
            errors++;
            $display("FAIL t6_count: got %0d required %0d", got_q.size() - s_got, N);
        end
        for (int k = 0; k < N && s_got + k < got_q.size(); k++) begin
            checks++;
            if (got_q[s_got + k] !== exp_elem(300, k)) begin
                errors++;
                $display("FAIL t6_elem%0d: got %h required %h", k, got_q[s_got + k], exp_elem(300, k));
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) begin
            mem_re[a] = 0;
            mem_im[a] = 0;
        end
        test_reset();
        test_transpose();
        test_saturation();
        test_backpressure();
        test_wrap();
        test_start_ignored();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
